// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one Data_Memory port between two requesters and holds each grant until ack.
// Grant appears 1 cycle after the request is sampled, acks pass through combinationally, and requesters wait by holding enable high.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 256,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       timeout_q, timeout_d;
  logic       owner_en;

  assign m0_data_o = mem_data_i;
  assign m1_data_o = mem_data_i;
  assign timeout_o = timeout_q;
  assign owner_en  = owner_q ? m1_enable_i : m0_enable_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      wd_cnt_q  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      wd_cnt_q  <= wd_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_d       = last_q;
    wd_cnt_d     = wd_cnt_q;
    timeout_d    = timeout_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    m0_ack_o     = 1'b0;
    m1_ack_o     = 1'b0;
    grant_o      = 2'b00;

    case (state_q)
      IDLE: begin
        if (m0_enable_i || m1_enable_i) begin
          state_d  = GRANT;
          // On contention the port that did not own the previous grant wins.
          owner_d  = (m0_enable_i && m1_enable_i) ? ~last_q : m1_enable_i;
          wd_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        mem_enable_o = owner_en;
        mem_write_o  = owner_q ? m1_write_i : m0_write_i;
        mem_addr_o   = owner_q ? m1_addr_i  : m0_addr_i;
        mem_data_o   = owner_q ? m1_data_i  : m0_data_i;
        m0_ack_o     = mem_ack_i & ~owner_q;
        m1_ack_o     = mem_ack_i & owner_q;
        grant_o      = owner_q ? 2'b10 : 2'b01;
        if (wd_cnt_q != 8'hFF)
          wd_cnt_d = wd_cnt_q + 8'd1;
        if (mem_ack_i || !owner_en) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wd_cnt_q == WD_LAST) begin
          state_d   = IDLE;
          last_d    = owner_q;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
